// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiplier and restoring divider
// sharing one 64-bit working register; fixed 33-cycle latency, one op in flight.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int ITERS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_data1,
  input  logic [XLEN-1:0] in_data2,
  input  logic            in_kill,
  output logic            out_busy,
  output logic            out_valid,
  output logic [XLEN-1:0] out_data
);

  localparam int CW = $clog2(ITERS) + 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2:0]          f3_q, f3_d;
  logic                sign1_q, sign1_d, sign2_q, sign2_d;
  logic                dzero_q, dzero_d;
  logic [XLEN-1:0]     data1_q, data1_d;
  logic [XLEN-1:0]     mag1_q, mag1_d, mag2_q, mag2_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic                out_valid_q, out_valid_d;
  logic [XLEN-1:0]     out_data_q, out_data_d;

  // Accept-time operand decode
  logic            s1_in, s2_in;
  logic [XLEN-1:0] m1_in, m2_in;
  always_comb begin
    s1_in = in_data1[XLEN-1] & (in_funct3 == 3'b001 || in_funct3 == 3'b010 ||
                                in_funct3 == 3'b100 || in_funct3 == 3'b110);
    s2_in = in_data2[XLEN-1] & (in_funct3 == 3'b001 || in_funct3 == 3'b100 ||
                                in_funct3 == 3'b110);
    m1_in = s1_in ? -in_data1 : in_data1;
    m2_in = s2_in ? -in_data2 : in_data2;
  end

  // Multiply step: acc = {partial_hi, multiplier_lo}; add when lsb set, then shift right.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  // Divide step: acc = {remainder, dividend/quotient}; shift in dividend msb, try subtract.
  logic [XLEN:0]     div_shift;
  logic [XLEN+1:0]   div_diff;
  logic [2*XLEN-1:0] div_next;
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mag1_q} : '0);
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, mag2_q};
    div_next  = div_diff[XLEN+1] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                 : {div_diff[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};
  end

  // Sign fix-up and result select
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, result;
  always_comb begin
    prod = (sign1_q ^ sign2_q) ? -acc_q : acc_q;
    quo  = acc_q[XLEN-1:0];
    rem  = acc_q[2*XLEN-1:XLEN];
    case (f3_q)
      3'b000:                 result = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: result = prod[2*XLEN-1:XLEN];
      3'b100:  result = dzero_q ? '1 : ((sign1_q ^ sign2_q) ? -quo : quo);
      3'b101:  result = dzero_q ? '1 : quo;
      3'b110:  result = dzero_q ? data1_q : (sign1_q ? -rem : rem);
      default: result = dzero_q ? data1_q : rem;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    f3_d        = f3_q;
    sign1_d     = sign1_q;
    sign2_d     = sign2_q;
    dzero_d     = dzero_q;
    data1_d     = data1_q;
    mag1_d      = mag1_q;
    mag2_d      = mag2_q;
    acc_d       = acc_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    if (in_kill) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid) begin
          state_d = S_CALC;
          cnt_d   = '0;
          f3_d    = in_funct3;
          sign1_d = s1_in;
          sign2_d = s2_in;
          dzero_d = (in_data2 == '0);
          data1_d = in_data1;
          mag1_d  = m1_in;
          mag2_d  = m2_in;
          acc_d   = in_funct3[2] ? {{XLEN{1'b0}}, m1_in} : {{XLEN{1'b0}}, m2_in};
        end
        S_CALC: begin
          acc_d = f3_q[2] ? div_next : mul_next;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(ITERS - 1)) state_d = S_FIX;
        end
        S_FIX: begin
          out_data_d  = result;
          out_valid_d = 1'b1;
          state_d     = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      f3_q        <= '0;
      sign1_q     <= 1'b0;
      sign2_q     <= 1'b0;
      dzero_q     <= 1'b0;
      data1_q     <= '0;
      mag1_q      <= '0;
      mag2_q      <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      f3_q        <= f3_d;
      sign1_q     <= sign1_d;
      sign2_q     <= sign2_d;
      dzero_q     <= dzero_d;
      data1_q     <= data1_d;
      mag1_q      <= mag1_d;
      mag2_q      <= mag2_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_busy  = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M corner cases plus random
// operands against a plain 64-bit arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [2:0]  in_funct3 = '0;
  logic [31:0] in_data1 = '0;
  logic [31:0] in_data2 = '0;
  logic        in_kill = 1'b0;
  logic        out_busy, out_valid;
  logic [31:0] out_data;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] last_res = '0;

  muldiv_unit dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_funct3(in_funct3),
    .in_data1(in_data1), .in_data2(in_data2), .in_kill(in_kill),
    .out_busy(out_busy), .out_valid(out_valid), .out_data(out_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    longint          sa, sb, ub_s, p;
    longint unsigned ua, ub, pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    ub_s = {32'b0, b};
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub_s; return p[63:32]; end
      3'd3: begin pu = ua * ub; return pu[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFFFFFF; p = sa / sb; return p[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFFFFFF; pu = ua / ub; return pu[31:0]; end
      3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
      default: begin if (b == 0) return a; pu = ua % ub; return pu[31:0]; end
    endcase
  endfunction

  function automatic logic [31:0] rnd_op();
    case ($urandom % 7)
      0: return 32'h0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return $urandom % 16;
      4: return -($urandom % 16);
      default: return $urandom;
    endcase
  endfunction

  // Drives one request from IDLE and reports latency, data and whether the strobe was one cycle.
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [31:0] d, output bit single);
    in_funct3 = f; in_data1 = a; in_data2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data1 = $urandom; in_data2 = $urandom; in_funct3 = 3'($urandom);
    lat = -1; d = 'x; single = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (out_valid) begin lat = k; d = out_data; break; end
    end
    if (lat > 0) begin
      @(posedge clk); #1;
      single = !out_valid;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    n_cmp++; if (out_data !== 32'h0) begin n_err++; $display("FAIL reset_data got=%h exp=00000000", out_data); end
    n_cmp++; if (out_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", out_busy); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (out_busy !== 1'b0) begin n_err++; $display("FAIL post_reset_busy got=%b exp=0", out_busy); end
  endtask

  task automatic run_list(input string tag, input logic [2:0] f[], input logic [31:0] a[],
                          input logic [31:0] b[], input logic [31:0] e[]);
    int lat; logic [31:0] d; bit sg;
    foreach (f[i]) begin
      do_op(f[i], a[i], b[i], lat, d, sg);
      n_cmp++; if (d !== e[i]) begin n_err++;
        $display("FAIL %s_data[%0d] f3=%0d a=%h b=%h got=%h exp=%h", tag, i, f[i], a[i], b[i], d, e[i]); end
      n_cmp++; if (lat != 33) begin n_err++; $display("FAIL %s_latency[%0d] got=%0d exp=33", tag, i, lat); end
      n_cmp++; if (!sg) begin n_err++; $display("FAIL %s_width[%0d] got=multi exp=single", tag, i); end
      last_res = e[i];
    end
  endtask

  task automatic test_mul();
    logic [2:0] f[]; logic [31:0] a[], b[], e[];
    f = '{3'd0, 3'd1, 3'd3, 3'd2};
    a = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    b = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    e = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF};
    run_list("mul_dir", f, a, b, e);
    f = new[24]; a = new[24]; b = new[24]; e = new[24];
    foreach (f[i]) begin
      f[i] = 3'(i % 4); a[i] = rnd_op(); b[i] = rnd_op(); e[i] = ref_model(f[i], a[i], b[i]);
    end
    run_list("mul_rand", f, a, b, e);
  endtask

  task automatic test_div();
    logic [2:0] f[]; logic [31:0] a[], b[], e[];
    f = '{3'd4, 3'd6, 3'd4, 3'd6, 3'd5, 3'd6, 3'd4};
    a = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'h80000000, 32'h80000000, 32'd5, 32'hFFFFFFF9, 32'hFFFFFFF9};
    b = '{32'd2, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd0};
    e = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFFF};
    run_list("div_dir", f, a, b, e);
    f = new[32]; a = new[32]; b = new[32]; e = new[32];
    foreach (f[i]) begin
      f[i] = 3'(4 + i % 4); a[i] = rnd_op(); b[i] = rnd_op(); e[i] = ref_model(f[i], a[i], b[i]);
    end
    run_list("div_rand", f, a, b, e);
  endtask

  task automatic test_kill();
    int lat; logic [31:0] d; bit sg; int seen;
    do_op(3'd5, 32'd100, 32'd7, lat, d, sg);
    n_cmp++; if (d !== 32'd14) begin n_err++; $display("FAIL kill_setup got=%h exp=0000000e", d); end
    in_funct3 = 3'd5; in_data1 = 32'd1000; in_data2 = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    in_kill = 1'b1;
    @(posedge clk); #1; in_kill = 1'b0;
    n_cmp++; if (out_busy !== 1'b0) begin n_err++; $display("FAIL kill_busy got=%b exp=0", out_busy); end
    // kill together with a request in IDLE drops the request
    in_valid = 1'b1; in_kill = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0; in_kill = 1'b0;
    n_cmp++; if (out_busy !== 1'b0) begin n_err++; $display("FAIL kill_drop_busy got=%b exp=0", out_busy); end
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) seen++; end
    n_cmp++; if (seen != 0) begin n_err++; $display("FAIL kill_no_valid got=%0d strobes exp=0", seen); end
    n_cmp++; if (out_data !== 32'd14) begin n_err++; $display("FAIL kill_data_hold got=%h exp=0000000e", out_data); end
    in_funct3 = 3'd5; in_data1 = 32'd1000; in_data2 = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (19) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_data !== 32'h0) begin n_err++; $display("FAIL rst_mid_data got=%h exp=00000000", out_data); end
    n_cmp++; if (out_busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy got=%b exp=0", out_busy); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) seen++; end
    n_cmp++; if (seen != 0) begin n_err++; $display("FAIL rst_no_valid got=%0d strobes exp=0", seen); end
    n_cmp++; if (out_data !== 32'h0) begin n_err++; $display("FAIL rst_data_hold got=%h exp=00000000", out_data); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a1, b1, a2, b2, e1, e2;
    int lat, seen;
    a1 = rnd_op(); b1 = rnd_op(); e1 = ref_model(3'd0, a1, b1);
    a2 = rnd_op(); b2 = rnd_op(); e2 = ref_model(3'd4, a2, b2);
    in_funct3 = 3'd0; in_data1 = a1; in_data2 = b1; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (33) begin @(posedge clk); #1; end
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_first_valid got=%b exp=1", out_valid); end
    n_cmp++; if (out_data !== e1) begin n_err++; $display("FAIL b2b_first_data got=%h exp=%h", out_data, e1); end
    in_funct3 = 3'd4; in_data1 = a2; in_data2 = b2; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    n_cmp++; if (out_busy !== 1'b1) begin n_err++; $display("FAIL b2b_accept_busy got=%b exp=1", out_busy); end
    lat = -1; seen = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k == 5) begin in_funct3 = 3'd3; in_data1 = 32'hFFFFFFFF; in_data2 = 32'h12345; in_valid = 1'b1; end
      if (k == 6) in_valid = 1'b0;
      @(posedge clk); #1;
      if (out_valid) begin
        seen++;
        if (lat < 0) begin
          lat = k;
          n_cmp++; if (out_data !== e2) begin n_err++; $display("FAIL b2b_second_data got=%h exp=%h", out_data, e2); end
        end
      end
    end
    n_cmp++; if (lat != 33) begin n_err++; $display("FAIL b2b_second_latency got=%0d exp=33", lat); end
    repeat (40) begin @(posedge clk); #1; if (out_valid) seen++; end
    n_cmp++; if (seen != 1) begin n_err++; $display("FAIL b2b_busy_ignored got=%0d strobes exp=1", seen); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_kill();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
